// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//
// Pipeline hazard detector that sits beside the ID stage. A registered
// scoreboard tracks the destination register of every instruction in the
// DEPTH stages after decode (entry 0 = EX, entry DEPTH-1 = WB). Each cycle the
// decode-stage sources are compared against it. On a read-after-write hazard a
// combinational stall holds PC and IF/ID and pushes a bubble into entry 0.
//
// Build option:
//   HDT_FWD_EN  defined   -> forwarding mode. Only a load in entry 0 whose
//                            destination is read by ID stalls. WB_BYPASS is
//                            ignored.
//               undefined -> full interlock. Any RAW match in the tracked
//                            entries stalls. Entry DEPTH-1 is excluded when
//                            WB_BYPASS=1.
//
// Parameters:
//   REG_W      register address width (register 0 is hardwired zero)
//   DEPTH      tracked stages after ID, 1..8
//   WB_BYPASS  1 = register file writes through, so the WB entry never stalls
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_valid                     real instruction present in ID
//   id_rs/id_rt, *_used          source addresses and read enables
//   id_rd, id_we, id_is_load     destination, write enable, load flag
//   flush                        squash all in-flight entries
//   stall                        combinational hold/bubble request
//   stall_cnt                    saturating count of stalled cycles
module hazard_scoreboard #(
  parameter int REG_W     = 4,
  parameter int DEPTH     = 3,
  parameter int WB_BYPASS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [15:0]      stall_cnt
);

  // Scoreboard entries {v, we, rd, ld}
  logic [DEPTH-1:0] v_reg, we_reg, ld_reg;
  logic [REG_W-1:0] rd_reg [DEPTH];

  logic [DEPTH-1:0] v_next, we_next, ld_next;
  logic [REG_W-1:0] rd_next [DEPTH];

  logic [DEPTH-1:0] rs_hit, rt_hit, hazard_vec;
  logic             hazard;
  logic             enter;

  logic [15:0]      stall_cnt_reg;

  // A stalled instruction stays in ID; a bubble goes down the pipe instead.
  assign enter = id_valid & ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Shift: entry 0 loads from ID, every other entry from its predecessor.
      if (gi == 0) begin : g_head
        assign v_next[gi]  = enter;
        assign we_next[gi] = id_we;
        assign ld_next[gi] = id_is_load;
        assign rd_next[gi] = id_rd;
      end else begin : g_tail
        assign v_next[gi]  = v_reg[gi-1];
        assign we_next[gi] = we_reg[gi-1];
        assign ld_next[gi] = ld_reg[gi-1];
        assign rd_next[gi] = rd_reg[gi-1];
      end

      // Writes to register 0 are discarded, so they can never be a dependency.
      assign rs_hit[gi] = v_reg[gi] & we_reg[gi] & (rd_reg[gi] != '0) &
                          (rd_reg[gi] == id_rs) & id_rs_used;
      assign rt_hit[gi] = v_reg[gi] & we_reg[gi] & (rd_reg[gi] != '0) &
                          (rd_reg[gi] == id_rt) & id_rt_used;

`ifdef HDT_FWD_EN
      // With forwarding, only a load still in EX cannot supply its result.
      if (gi == 0) begin : g_fwd_head
        assign hazard_vec[gi] = ld_reg[gi] & (rs_hit[gi] | rt_hit[gi]);
      end else begin : g_fwd_tail
        assign hazard_vec[gi] = 1'b0;
      end
`else
      // Write-through register file makes the WB producer visible to ID.
      if ((WB_BYPASS != 0) && (gi == DEPTH - 1)) begin : g_wb_bypass
        assign hazard_vec[gi] = 1'b0;
      end else begin : g_interlock
        assign hazard_vec[gi] = rs_hit[gi] | rt_hit[gi];
      end
`endif
    end
  endgenerate

  assign hazard = |hazard_vec;

  // Gated by flush (the ID instruction is squashed anyway) and by rst so the
  // stall drops in the very cycle reset is applied.
  assign stall = id_valid & hazard & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_reg <= '0;
    end else begin
      v_reg <= v_next;
    end
    // Payload fields are only meaningful when v is set, so they shift freely.
    we_reg <= we_next;
    ld_reg <= ld_next;
    rd_reg <= rd_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  // Load flags beyond entry 0 (all of them in full-interlock mode) are carried
  // for completeness of the entry record but never inspected.
  logic unused_ld;
  assign unused_ld = ^ld_reg;

`ifdef HDT_FWD_EN
  localparam int unused_wb_bypass = WB_BYPASS;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard.
// dut     : DEPTH=3, WB_BYPASS=0
// dut_bp  : DEPTH=3, WB_BYPASS=1 (same ID stimulus as dut)
// dut_sat : DEPTH=8, fed a permanent self-dependent instruction to drive the
//           stall counter into saturation (full-interlock build only).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_rs, id_rt, id_rd;
  logic        id_rs_used, id_rt_used, id_we, id_is_load;
  logic        flush;

  logic        stall, stall_bp, stall_sat;
  logic [15:0] cnt, cnt_bp, cnt_sat;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .WB_BYPASS(0)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .stall_cnt(cnt)
  );

  hazard_scoreboard #(.REG_W(4), .DEPTH(3), .WB_BYPASS(1)) dut_bp (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_bp), .stall_cnt(cnt_bp)
  );

  // Reads r2 and writes r2: it stalls behind its own previous copy forever.
  hazard_scoreboard #(.REG_W(4), .DEPTH(8), .WB_BYPASS(0)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(1'b1),
    .id_rs(4'd2), .id_rt(4'd0), .id_rs_used(1'b1), .id_rt_used(1'b0),
    .id_rd(4'd2), .id_we(1'b1), .id_is_load(1'b1), .flush(1'b0),
    .stall(stall_sat), .stall_cnt(cnt_sat)
  );

  typedef struct {
    string tag;
    logic  s;
    logic  s_bp;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input bit v, input logic [3:0] rs, input bit rsu,
                        input logic [3:0] rt, input bit rtu,
                        input logic [3:0] rd, input bit we, input bit ld);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_rd      = rd;
    id_we      = we;
    id_is_load = ld;
    flush      = 1'b0;
  endtask

  // One cycle: queue expected stalls, compare at negedge, return at posedge+1.
  task automatic tick(input string tag, input bit e_s, input bit e_bp);
    exp_t e;
    e.tag  = tag;
    e.s    = e_s;
    e.s_bp = e_bp;
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val({e.tag, "/stall"},    {31'd0, stall},    {31'd0, e.s});
    check_val({e.tag, "/stall_bp"}, {31'd0, stall_bp}, {31'd0, e.s_bp});
    $display("cycle %-12s stall=%0b stall_bp=%0b cnt=%0d cnt_bp=%0d",
             e.tag, stall, stall_bp, cnt, cnt_bp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag, input int e_main, input int e_bp);
    check_val({tag, "/cnt"},    {16'd0, cnt},    e_main);
    check_val({tag, "/cnt_bp"}, {16'd0, cnt_bp}, e_bp);
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick("drain", 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_id(1, 2, 1, 0, 0, 2, 1, 0);
    @(posedge clk);
    #1;
    tick("rst_a", 0, 0);
    tick("rst_b", 0, 0);
    rst = 1'b0;
    check_cnts("rst", 0, 0);

    // Empty scoreboard: no stall on the first cycle out of reset.
    set_id(1, 2, 1, 0, 0, 4'hD, 1, 0);
    tick("first", 0, 0);

`ifndef HDT_FWD_EN
    // No hazard against entries F, E, D.
    set_id(1, 0, 0, 0, 0, 4'hE, 1, 0); tick("fill_e", 0, 0);
    set_id(1, 0, 0, 0, 0, 4'hF, 1, 0); tick("fill_f", 0, 0);
    set_id(1, 0, 1, 1, 1, 0, 0, 0);    tick("nohaz", 0, 0);
    check_cnts("nohaz", 0, 0);
    drain();

    // Back-to-back RAW: 3 stall cycles, 2 with WB bypass.
    set_id(1, 0, 0, 0, 0, 2, 1, 0); tick("raw_issue", 0, 0);
    set_id(1, 2, 1, 0, 0, 4, 1, 0);
    tick("raw1", 1, 1);
    tick("raw2", 1, 1);
    tick("raw3", 1, 0);
    tick("raw4", 0, 0);
    check_cnts("raw", 3, 2);
    drain();

    // Masking: r0, unused sources, invalid ID.
    set_id(1, 0, 0, 0, 0, 0, 1, 0); tick("zero_issue", 0, 0);
    set_id(1, 0, 1, 0, 1, 5, 0, 0); tick("zero_read", 0, 0);
    drain();
    set_id(1, 0, 0, 0, 0, 6, 1, 0); tick("unused_iss", 0, 0);
    set_id(1, 6, 0, 6, 0, 0, 0, 0); tick("unused_rd", 0, 0);
    set_id(0, 6, 1, 6, 1, 0, 0, 0); tick("invalid_rd", 0, 0);
    drain();

    // Flush in the second stall cycle.
    set_id(1, 0, 0, 0, 0, 7, 1, 0); tick("fl_issue", 0, 0);
    set_id(1, 7, 1, 0, 0, 9, 1, 0);
    tick("fl_stall1", 1, 1);
    flush = 1'b1;
    tick("fl_flush", 0, 0);
    flush = 1'b0;
    tick("fl_after", 0, 0);
    check_cnts("fl", 4, 3);
    tick("fl_next", 0, 0);
    drain();

    // rs and rt hit different entries; stall until the younger one retires.
    set_id(1, 0, 0, 0, 0, 3, 1, 0); tick("mm_a", 0, 0);
    set_id(1, 0, 0, 0, 0, 4, 1, 0); tick("mm_b", 0, 0);
    set_id(1, 3, 1, 4, 1, 5, 1, 0);
    tick("mm1", 1, 1);
    tick("mm2", 1, 1);
    tick("mm3", 1, 0);
    tick("mm4", 0, 0);
    check_cnts("mm", 7, 5);
    drain();
`else
    drain();
    // Load-use: exactly one stall cycle.
    set_id(1, 0, 0, 0, 0, 5, 1, 1); tick("ld_issue", 0, 0);
    set_id(1, 0, 0, 5, 1, 6, 1, 0);
    tick("lu1", 1, 1);
    tick("lu2", 0, 0);
    check_cnts("lu", 1, 1);
    drain();

    // ALU producer: forwarded, no stall.
    set_id(1, 0, 0, 0, 0, 5, 1, 0); tick("alu_issue", 0, 0);
    set_id(1, 0, 0, 5, 1, 6, 1, 0); tick("alu_read", 0, 0);
    drain();

    // Load, one unrelated instruction, then use: no stall.
    set_id(1, 0, 0, 0, 0, 5, 1, 1); tick("gap_ld", 0, 0);
    set_id(1, 0, 0, 0, 0, 1, 1, 0); tick("gap_mid", 0, 0);
    set_id(1, 5, 1, 0, 0, 6, 1, 0); tick("gap_use", 0, 0);
    check_cnts("fwd", 1, 1);
    drain();
    set_id(1, 0, 0, 0, 0, 2, 1, 1); tick("rs_issue", 0, 0);
`endif

`ifndef HDT_FWD_EN
    set_id(1, 0, 0, 0, 0, 2, 1, 0); tick("rs_issue", 0, 0);
`endif
    // Reset in the middle of a stall.
    set_id(1, 2, 1, 0, 0, 4, 1, 0);
    tick("rs_stall", 1, 1);
    rst = 1'b1;
    tick("rs_rst", 0, 0);
    rst = 1'b0;
    check_cnts("rs", 0, 0);
    tick("rs_after", 0, 0);
    drain();

`ifndef HDT_FWD_EN
    // Saturation: DEPTH=8 self-dependent instruction stalls 8 of every 9 cycles.
    rst = 1'b1;
    tick("sat_rst", 0, 0);
    rst = 1'b0;
    check_val("sat_start", {31'd0, stall_sat}, 32'd0);
    @(posedge clk);
    #1;
    check_val("sat_first", {31'd0, stall_sat}, 32'd1);
    repeat (73718) @(posedge clk);
    #1;
    check_val("sat_65528", {16'd0, cnt_sat}, 32'd65528);
    $display("sat edges=73719 cnt_sat=%0d", cnt_sat);
    repeat (7) @(posedge clk);
    #1;
    check_val("sat_65534", {16'd0, cnt_sat}, 32'd65534);
    $display("sat edges=73726 cnt_sat=%0d", cnt_sat);
    repeat (74) @(posedge clk);
    #1;
    check_val("sat_hold", {16'd0, cnt_sat}, 32'h0000FFFF);
    $display("sat edges=73800 cnt_sat=%0d", cnt_sat);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
